// File: rtl/teng_mac_lane_if.sv
// teng_mac_lane_if: GT word, AXIS TX/RX and PHY status signals of one teng_mac_lane
interface teng_mac_lane_if;
    logic        tx_fsm_reset_done_i;
    logic        rx_fsm_reset_done_i;
    logic [31:0] tx_data_o;
    logic [31:0] rx_data_i;
    logic        link_up_o;
    logic [31:0] tx_data_i;
    logic [1:0]  tx_vldb_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        tx_last_i;
    logic        tx_user_i;
    logic        tx_status_o;
    logic        tx_rsp_valid_o;
    logic [31:0] rx_data_o;
    logic [1:0]  rx_vldb_o;
    logic        rx_valid_o;
    logic        rx_last_o;
    logic        rx_user_o;
    modport slave (
        input  tx_fsm_reset_done_i, rx_fsm_reset_done_i, rx_data_i,
        input  tx_data_i, tx_vldb_i, tx_valid_i, tx_last_i, tx_user_i,
        output tx_data_o, link_up_o, tx_ready_o, tx_status_o, tx_rsp_valid_o,
        output rx_data_o, rx_vldb_o, rx_valid_o, rx_last_o, rx_user_o
    );
    modport master (
        output tx_fsm_reset_done_i, rx_fsm_reset_done_i, rx_data_i,
        output tx_data_i, tx_vldb_i, tx_valid_i, tx_last_i, tx_user_i,
        input  tx_data_o, link_up_o, tx_ready_o, tx_status_o, tx_rsp_valid_o,
        input  rx_data_o, rx_vldb_o, rx_valid_o, rx_last_o, rx_user_o
    );
endinterface

// File: rtl/teng_mac_lane.sv
// teng_mac_lane: single-lane framing MAC, AXIS <-> 32-bit GT words with in-band control words.
// Define TENG_MAC_LOOPBACK_EN to feed the RX parser from the registered TX word stream.
module teng_mac_lane #(
    parameter int LINK_UP_COUNT = 16
) (
    input logic            sys_clk_i,
    input logic            sys_reset_i,
    teng_mac_lane_if.slave bus
);
    localparam logic [31:0] IDLE  = 32'h0707_0707;
    localparam logic [31:0] START = 32'hFB55_5555;
    localparam logic [31:0] ESC   = 32'hBC00_0000;
    localparam logic [31:0] FILL  = 32'hBC00_00FF;
    localparam logic [7:0]  LINK_TH = 8'(LINK_UP_COUNT - 1);

    function automatic logic rsvd(input logic [31:0] w);
        rsvd = w[31:24] inside {8'h07, 8'hFB, 8'hFD, 8'hBC};
    endfunction

    typedef enum logic [1:0] {T_IDLE, T_DATA, T_TERM, T_GAP} tx_state_t;
    typedef enum logic [1:0] {R_OUT, R_FRAME, R_ESC} rx_state_t;

    tx_state_t   ts, ts_n;
    logic [31:0] tx_w_n;
    logic        esc_sent, esc_n;
    logic        t_user, t_user_n;
    logic [1:0]  t_vldb, t_vldb_n;
    logic        rsp_n, status_n;
    logic        tx_done;

    assign tx_done = bus.tx_fsm_reset_done_i;

    always_comb begin
        ts_n = ts;
        tx_w_n = IDLE;
        esc_n = 1'b0;
        t_user_n = t_user;
        t_vldb_n = t_vldb;
        rsp_n = 1'b0;
        status_n = bus.tx_status_o;
        bus.tx_ready_o = 1'b0;
        case (ts)
            T_IDLE: if (bus.tx_valid_i && tx_done) begin
                tx_w_n = START;
                ts_n = T_DATA;
            end
            T_DATA: begin
                // a reserved-looking beat is held off one cycle while ESC goes out ahead of it
                bus.tx_ready_o = tx_done && !(bus.tx_valid_i && rsvd(bus.tx_data_i) && !esc_sent);
                esc_n = esc_sent;
                if (!tx_done) begin
                    tx_w_n = {8'hFD, 21'h0, 1'b1, 2'd3};
                    rsp_n = 1'b1;
                    status_n = 1'b0;
                    ts_n = T_GAP;
                end else if (!bus.tx_valid_i) begin
                    tx_w_n = FILL;
                end else if (!bus.tx_ready_o) begin
                    tx_w_n = ESC;
                    esc_n = 1'b1;
                end else begin
                    tx_w_n = bus.tx_data_i;
                    esc_n = 1'b0;
                    if (bus.tx_last_i) begin
                        t_user_n = bus.tx_user_i;
                        t_vldb_n = bus.tx_vldb_i;
                        ts_n = T_TERM;
                    end
                end
            end
            T_TERM: begin
                tx_w_n = {8'hFD, 21'h0, t_user, t_vldb};
                rsp_n = 1'b1;
                status_n = 1'b1;
                ts_n = T_GAP;
            end
            default: ts_n = T_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            ts <= T_IDLE;
            bus.tx_data_o <= IDLE;
            esc_sent <= 1'b0;
            t_user <= 1'b0;
            t_vldb <= 2'd0;
            bus.tx_rsp_valid_o <= 1'b0;
            bus.tx_status_o <= 1'b0;
        end else begin
            ts <= ts_n;
            bus.tx_data_o <= tx_w_n;
            esc_sent <= esc_n;
            t_user <= t_user_n;
            t_vldb <= t_vldb_n;
            bus.tx_rsp_valid_o <= rsp_n;
            bus.tx_status_o <= status_n;
        end
    end

    logic [31:0] rx_src, rx_q;
    logic        rx_done;
`ifdef TENG_MAC_LOOPBACK_EN
    assign rx_src = bus.tx_data_o;
    assign rx_done = bus.tx_fsm_reset_done_i;
`else
    assign rx_src = bus.rx_data_i;
    assign rx_done = bus.rx_fsm_reset_done_i;
`endif

    rx_state_t   rs, rs_n;
    logic [7:0]  cnt, cnt_n;
    logic        link_n;
    logic [31:0] hold, hold_n;
    logic        hold_vld, hold_vld_n;
    logic        is_idle, is_start, is_esc, is_fill, is_term, is_rsvd, lost;
    logic        take, term, trunc, emit;

    assign is_idle  = rx_q == IDLE;
    assign is_start = rx_q == START;
    assign is_esc   = rx_q == ESC;
    assign is_fill  = rx_q == FILL;
    assign is_term  = rx_q[31:24] == 8'hFD;
    assign is_rsvd  = rsvd(rx_q);
    assign lost     = !rx_done || !bus.link_up_o;

    always_comb begin
        cnt_n = (!rx_done || !is_idle) ? 8'd0 : (cnt == 8'hFF ? cnt : cnt + 8'd1);
        link_n = rx_done && (bus.link_up_o ? !(rs == R_OUT && !is_idle && !is_start)
                                           : (is_idle && cnt >= LINK_TH));
        take  = !lost && (rs == R_ESC || (rs == R_FRAME && !is_rsvd));
        term  = !lost && rs == R_FRAME && is_term;
        // IDLE, START, unknown reserved words and link loss all cut the frame short
        trunc = rs != R_OUT && (lost || (rs == R_FRAME && is_rsvd && !is_esc && !is_fill && !is_term));
        emit  = hold_vld && (take || term || trunc);
        hold_n = take ? rx_q : hold;
        hold_vld_n = take || (hold_vld && !(term || trunc));
        rs_n = rs == R_OUT ? ((is_start && bus.link_up_o) ? R_FRAME : R_OUT)
             : lost ? R_OUT
             : rs == R_ESC ? R_FRAME
             : is_esc ? R_ESC
             : (is_fill || is_start || !is_rsvd) ? R_FRAME : R_OUT;
    end

    always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            rx_q <= 32'd0;
            rs <= R_OUT;
            cnt <= 8'd0;
            bus.link_up_o <= 1'b0;
            hold <= 32'd0;
            hold_vld <= 1'b0;
            bus.rx_data_o <= 32'd0;
            bus.rx_vldb_o <= 2'd0;
            bus.rx_valid_o <= 1'b0;
            bus.rx_last_o <= 1'b0;
            bus.rx_user_o <= 1'b0;
        end else begin
            rx_q <= rx_src;
            rs <= rs_n;
            cnt <= cnt_n;
            bus.link_up_o <= link_n;
            hold <= hold_n;
            hold_vld <= hold_vld_n;
            bus.rx_data_o <= emit ? hold : bus.rx_data_o;
            bus.rx_vldb_o <= emit ? (term ? rx_q[1:0] : 2'd3) : bus.rx_vldb_o;
            bus.rx_valid_o <= emit;
            bus.rx_last_o <= emit && (term || trunc);
            bus.rx_user_o <= emit && (term ? rx_q[2] : trunc);
        end
    end
endmodule

// File: tb/tb_teng_mac_lane.sv
// tb_teng_mac_lane: scoreboard bench for teng_mac_lane, TX words/responses and RX beats checked from queues
module tb_teng_mac_lane;
    localparam logic [31:0] IDLE  = 32'h0707_0707;
    localparam logic [31:0] START = 32'hFB55_5555;
    localparam logic [31:0] ESC   = 32'hBC00_0000;
    localparam logic [31:0] FILL  = 32'hBC00_00FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    teng_mac_lane_if bus();
    teng_mac_lane #(.LINK_UP_COUNT(16)) dut (.sys_clk_i(clk), .sys_reset_i(rst), .bus(bus));

    logic        lb_sel;
    logic [31:0] rx_drv;
    assign bus.rx_data_i = lb_sel ? bus.tx_data_o : rx_drv;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] tx_q[$];
    logic        rsp_q[$];
    logic [35:0] rx_q[$];
    logic [31:0] fw[$];
    logic [31:0] prev_w = IDLE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rsvd(input logic [31:0] w);
        rsvd = w[31:24] == 8'h07 || w[31:24] == 8'hFB || w[31:24] == 8'hFD || w[31:24] == 8'hBC;
    endfunction

    always @(negedge clk) if (!rst) begin
        if (bus.tx_data_o != IDLE) begin
            if (tx_q.size() == 0) check("tx_extra", 64'(bus.tx_data_o), 64'(IDLE));
            else check("tx_word", 64'(bus.tx_data_o), 64'(tx_q.pop_front()));
        end
        if (prev_w[31:24] == 8'hFD) check("tx_gap", 64'(bus.tx_data_o), 64'(IDLE));
        prev_w = bus.tx_data_o;
        if (bus.tx_rsp_valid_o) begin
            if (rsp_q.size() == 0) check("rsp_extra", 64'(bus.tx_rsp_valid_o), 64'd0);
            else begin
                check("rsp_status", 64'(bus.tx_status_o), 64'(rsp_q.pop_front()));
                check("rsp_term", 64'(bus.tx_data_o[31:24]), 64'hFD);
            end
        end
        if (bus.rx_valid_o) begin
            if (rx_q.size() == 0) check("rx_extra", 64'(bus.rx_valid_o), 64'd0);
            else check("rx_beat", 64'({bus.rx_last_o, bus.rx_user_o, bus.rx_vldb_o, bus.rx_data_o}),
                       64'(rx_q.pop_front()));
        end
    end

    task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] v, input logic u,
                        input int exp_stall);
        int st = 0;
        logic r;
        bus.tx_data_i = d;
        bus.tx_last_i = l;
        bus.tx_vldb_i = v;
        bus.tx_user_i = u;
        bus.tx_valid_i = 1'b1;
        forever begin
            #1 r = bus.tx_ready_o;
            @(negedge clk);
            if (r || st > 20) break;
            st++;
        end
        check("tx_stall", 64'(st), 64'(exp_stall));
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic send(input logic [1:0] v, input logic u, input int gap_at);
        int n = fw.size();
        tx_q.push_back(START);
        for (int i = 0; i < n; i++) begin
            logic l = (i == n - 1);
            if (i == gap_at) begin
                tx_q.push_back(FILL);
                @(negedge clk);
            end
            if (rsvd(fw[i])) tx_q.push_back(ESC);
            tx_q.push_back(fw[i]);
            if (l) tx_q.push_back({8'hFD, 21'h0, u, v});
            if (lb_sel) rx_q.push_back({l, l & u, l ? v : 2'd3, fw[i]});
            beat(fw[i], l, v, u, int'(i == 0) + int'(rsvd(fw[i])));
        end
        rsp_q.push_back(1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_link();
        int n = 0;
        while (!bus.link_up_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("link_relink", 64'(bus.link_up_o), 64'd1);
    endtask

    task automatic rx_send(input logic [31:0] w);
        rx_drv = w;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_fsm_reset_done_i = 1'b0;
        bus.rx_fsm_reset_done_i = 1'b0;
        bus.tx_data_i = 32'd0;
        bus.tx_vldb_i = 2'd0;
        bus.tx_valid_i = 1'b0;
        bus.tx_last_i = 1'b0;
        bus.tx_user_i = 1'b0;
        lb_sel = 1'b0;
        rx_drv = IDLE;
        repeat (3) @(negedge clk);
        check("rst_tx_data", 64'(bus.tx_data_o), 64'(IDLE));
        check("rst_tx_ready", 64'(bus.tx_ready_o), 64'd0);
        check("rst_tx_status", 64'({bus.tx_status_o, bus.tx_rsp_valid_o}), 64'd0);
        check("rst_link", 64'(bus.link_up_o), 64'd0);
        check("rst_rx_ctl", 64'({bus.rx_valid_o, bus.rx_last_o, bus.rx_user_o, bus.rx_vldb_o}), 64'd0);
        check("rst_rx_data", 64'(bus.rx_data_o), 64'd0);
        bus.tx_fsm_reset_done_i = 1'b1;
        bus.rx_fsm_reset_done_i = 1'b1;
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check("link_early", 64'(bus.link_up_o), 64'd0);
        @(negedge clk);
        check("link_at_16", 64'(bus.link_up_o), 64'd1);

        lb_sel = 1'b1;
        fw.delete(); fw.push_back(32'h1122_3344); fw.push_back(32'h5566_7788);
        send(2'd1, 1'b0, -1);
        fw.delete(); fw.push_back(32'hFB00_0000); fw.push_back(32'h0BAD_F00D); fw.push_back(32'hBC00_00FF);
        send(2'd2, 1'b1, 1);
        fw.delete(); fw.push_back(32'hCAFE_BABE);
        send(2'd0, 1'b0, -1);

        tx_q.push_back(START);
        tx_q.push_back(32'hDEAD_BEEF);
        tx_q.push_back(32'hFD00_0007);
        rsp_q.push_back(1'b0);
`ifndef TENG_MAC_LOOPBACK_EN
        rx_q.push_back({1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF});
`endif
        beat(32'hDEAD_BEEF, 1'b0, 2'd3, 1'b0, 1);
        bus.tx_fsm_reset_done_i = 1'b0;
        repeat (4) @(negedge clk);
        bus.tx_fsm_reset_done_i = 1'b1;
        repeat (3) @(negedge clk);
        wait_link();

`ifndef TENG_MAC_LOOPBACK_EN
        lb_sel = 1'b0;
        rx_drv = IDLE;
        repeat (3) @(negedge clk);
        rx_q.push_back({1'b1, 1'b1, 2'd3, 32'hAAAA_AAAA});
        rx_send(START);
        rx_send(32'hAAAA_AAAA);
        rx_drv = IDLE;
        @(negedge clk);
        check("rx_lat_early", 64'(bus.rx_valid_o), 64'd0);
        @(negedge clk);
        check("rx_lat", 64'(bus.rx_valid_o), 64'd1);
        rx_send(IDLE);

        rx_q.push_back({1'b0, 1'b0, 2'd3, 32'h0102_0304});
        rx_q.push_back({1'b1, 1'b1, 2'd2, 32'h0506_0708});
        rx_send(START); rx_send(32'h0102_0304); rx_send(32'h0506_0708);
        rx_send(FILL); rx_send(32'hFD00_0006); rx_send(IDLE);

        rx_q.push_back({1'b1, 1'b0, 2'd3, 32'h0707_0707});
        rx_send(START); rx_send(ESC); rx_send(32'h0707_0707); rx_send(32'hFD00_0003); rx_send(IDLE);

        rx_send(START); rx_send(32'hFD00_0001); rx_send(IDLE);

        rx_q.push_back({1'b1, 1'b1, 2'd3, 32'h1111_1111});
        rx_q.push_back({1'b1, 1'b0, 2'd2, 32'h2222_2222});
        rx_send(START); rx_send(32'h1111_1111); rx_send(START);
        rx_send(32'h2222_2222); rx_send(32'hFD00_0002); rx_send(IDLE);

        rx_q.push_back({1'b1, 1'b1, 2'd3, 32'h3333_3333});
        rx_send(START); rx_send(32'h3333_3333); rx_send(32'hBC00_1234); rx_send(IDLE); rx_send(IDLE);
        check("link_keep", 64'(bus.link_up_o), 64'd1);

        rx_send(32'h1234_5678);
        rx_drv = IDLE;
        @(negedge clk);
        check("link_drop_word", 64'(bus.link_up_o), 64'd0);
        wait_link();

        rx_q.push_back({1'b1, 1'b1, 2'd3, 32'h4444_4444});
        rx_send(START); rx_send(32'h4444_4444); rx_send(32'h5555_5555);
        bus.rx_fsm_reset_done_i = 1'b0;
        @(negedge clk);
        check("link_drop_done", 64'(bus.link_up_o), 64'd0);
        rx_drv = IDLE;
        bus.rx_fsm_reset_done_i = 1'b1;
        wait_link();
`endif

        repeat (6) @(negedge clk);
        check("tx_q_left", 64'(tx_q.size()), 64'd0);
        check("rsp_q_left", 64'(rsp_q.size()), 64'd0);
        check("rx_q_left", 64'(rx_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
